// File: rtl/xup_tff_decode_vector.sv
// xup_tff_decode_vector: recovers per-bit toggles from sampled T-flip-flop state with a one-deep output register
module xup_tff_decode_vector #(
    parameter int SIZE          = 4,
    parameter int DELAY         = 3,
    parameter int CNT_W         = 16,
    parameter bit ZERO_SUPPRESS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SIZE-1:0]  q_in,
    input  logic             en,
    input  logic             clr,
    input  logic             out_ready,
    output logic [SIZE-1:0]  t_out,
    output logic             t_valid,
    output logic             primed,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             overflow
);
    typedef enum logic {UNPRIMED, RUN} state_t;
    state_t state, state_n;
    logic [SIZE-1:0] q_prev, t;
    logic sample, emit, load, drop;
    logic [CNT_W:0] pop, sum;
    logic [CNT_W-1:0] cnt_n;
    if (DELAY < 0) begin : g_bad_delay
        $error("DELAY must be non-negative");
    end
    assign primed = state == RUN;
    always_comb begin
        t = q_in ^ q_prev;
        sample = en && state == RUN;
        emit = sample && !(ZERO_SUPPRESS && t == '0);
        load = emit && (!t_valid || out_ready);
        drop = emit && t_valid && !out_ready;
        state_n = clr ? UNPRIMED : (en ? RUN : state);
        pop = '0;
        for (int i = 0; i < SIZE; i++) pop = pop + (CNT_W+1)'(t[i]);
        sum = {1'b0, toggle_cnt} + pop;
        cnt_n = !sample ? toggle_cnt : (sum[CNT_W] ? '1 : sum[CNT_W-1:0]);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= UNPRIMED;
        else state <= state_n;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_prev <= '0;
            t_out <= '0;
            t_valid <= 1'b0;
            toggle_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            q_prev <= '0;
            t_out <= '0;
            t_valid <= 1'b0;
            toggle_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (en) q_prev <= q_in;
            toggle_cnt <= cnt_n;
            t_valid <= load || (t_valid && !out_ready);
            if (load) t_out <= t;
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_xup_tff_decode_vector.sv
// tb_xup_tff_decode_vector: randomized and directed checks of two configurations against a behavioural model
module tb_xup_tff_decode_vector;
    logic clk = 1'b0, reset = 1'b0, en = 1'b0, clr = 1'b0, out_ready = 1'b0;
    logic [3:0] q_in = '0;
    logic [3:0] a_t_out, b_t_out;
    logic a_t_valid, a_primed, a_overflow, b_t_valid, b_primed, b_overflow;
    logic [15:0] a_cnt;
    logic [3:0] b_cnt;
    int checks = 0, errors = 0;
    typedef struct {bit primed; bit [3:0] prev; bit [3:0] tout; bit tv; int cnt; bit ovf;} mdl_t;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    xup_tff_decode_vector dut_a (.clk(clk), .reset(reset), .q_in(q_in), .en(en), .clr(clr),
        .out_ready(out_ready), .t_out(a_t_out), .t_valid(a_t_valid), .primed(a_primed),
        .toggle_cnt(a_cnt), .overflow(a_overflow));
    xup_tff_decode_vector #(.CNT_W(4), .ZERO_SUPPRESS(1'b1)) dut_b (.clk(clk), .reset(reset),
        .q_in(q_in), .en(en), .clr(clr), .out_ready(out_ready), .t_out(b_t_out),
        .t_valid(b_t_valid), .primed(b_primed), .toggle_cnt(b_cnt), .overflow(b_overflow));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the specified behaviour, evaluated on the inputs present at the edge
    task automatic apply(inout mdl_t m, input bit zs, input int cmax);
        bit [3:0] t;
        bit loaded = 0;
        if (clr) begin
            m = '{default: 0};
            return;
        end
        if (en) begin
            if (m.primed) begin
                t = q_in ^ m.prev;
                m.cnt = (m.cnt + $countones(t) > cmax) ? cmax : m.cnt + $countones(t);
                if (!(zs && t == 0)) begin
                    if (!m.tv || out_ready) begin
                        m.tout = t;
                        loaded = 1;
                    end else m.ovf = 1;
                end
            end
            m.primed = 1;
            m.prev = q_in;
        end
        if (loaded) m.tv = 1;
        else if (m.tv && out_ready) m.tv = 0;
    endtask

    task automatic compare_all();
        check("a_t_out", 32'(a_t_out), 32'(ma.tout));
        check("a_t_valid", 32'(a_t_valid), 32'(ma.tv));
        check("a_primed", 32'(a_primed), 32'(ma.primed));
        check("a_toggle_cnt", 32'(a_cnt), 32'(ma.cnt));
        check("a_overflow", 32'(a_overflow), 32'(ma.ovf));
        check("b_t_out", 32'(b_t_out), 32'(mb.tout));
        check("b_t_valid", 32'(b_t_valid), 32'(mb.tv));
        check("b_primed", 32'(b_primed), 32'(mb.primed));
        check("b_toggle_cnt", 32'(b_cnt), 32'(mb.cnt));
        check("b_overflow", 32'(b_overflow), 32'(mb.ovf));
    endtask

    task automatic cyc(input bit e, input bit c, input bit r, input bit [3:0] qv);
        en = e; clr = c; out_ready = r; q_in = qv;
        @(posedge clk);
        apply(ma, 0, 65535);
        apply(mb, 1, 15);
        #1 compare_all();
    endtask

    // Reset pulse placed between clock edges so the clear must be asynchronous
    task automatic areset();
        #2 reset = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};
        #1 compare_all();
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        bit [3:0] tq;
        bit [3:0] tv [3] = '{4'b1010, 4'b0011, 4'b1111};
        ma = '{default: 0};
        mb = '{default: 0};
        #2 compare_all();
        @(negedge clk) reset = 1'b1;
        // basic prime then first toggle
        cyc(1, 0, 1, 4'b0000);
        check("prime_no_valid", 32'(a_t_valid), 0);
        cyc(1, 0, 1, 4'b0101);
        check("first_t", 32'(a_t_out), 32'h5);
        check("first_cnt", 32'(a_cnt), 2);
        // T-flip-flop vector driven by known toggles
        cyc(0, 1, 1, 4'b0000);
        tq = '0;
        cyc(1, 0, 1, tq);
        foreach (tv[i]) begin
            tq ^= tv[i];
            cyc(1, 0, 1, tq);
            check("tff_t", 32'(a_t_out), 32'(tv[i]));
        end
        check("tff_cnt", 32'(a_cnt), 8);
        // backpressure drop and later transfer
        cyc(0, 1, 1, 4'b0000);
        cyc(1, 0, 0, 4'b0000);
        cyc(1, 0, 0, 4'b0001);
        cyc(1, 0, 0, 4'b1001);
        check("held_t", 32'(a_t_out), 32'h1);
        check("ovf_set", 32'(a_overflow), 1);
        cyc(0, 0, 1, 4'b0000);
        check("drained", 32'(a_t_valid), 0);
        cyc(1, 0, 1, 4'b0000);
        check("after_drop_t", 32'(a_t_out), 32'h9);
        // zero suppression and saturation
        cyc(0, 1, 1, 4'b0000);
        repeat (4) cyc(1, 0, 1, 4'b1100);
        check("zs_no_valid", 32'(b_t_valid), 0);
        check("zs_cnt", 32'(b_cnt), 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, (i % 2 == 0) ? 4'b0011 : 4'b1100);
        check("sat_cnt", 32'(b_cnt), 15);
        check("nosat_cnt", 32'(a_cnt), 20);
        // clear beats enable while a result is held and overflow is set
        cyc(1, 0, 0, 4'b1111);
        cyc(1, 0, 0, 4'b0000);
        check("pre_clr_ovf", 32'(a_overflow), 1);
        cyc(1, 1, 0, 4'b1010);
        check("clr_primed", 32'(a_primed), 0);
        check("clr_cnt", 32'(a_cnt), 0);
        cyc(1, 0, 1, 4'b0110);
        areset();
        cyc(1, 0, 1, 4'b0011);
        check("reprime_only", 32'(a_t_valid), 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 1'($urandom),
                4'($urandom));
            if ($urandom_range(0, 60) == 0) areset();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xup_tff_decode_vector.md
XUP_TFF_DECODE_VECTOR -- requirements
Module: xup_tff_decode_vector

Interface
REQ-001 SHALL have parameter SIZE, default 4: width of the sampled toggle-state vector and of the recovered toggle vector.
REQ-002 SHALL have parameter DELAY, default 3: intra-assignment delay in ns on every registered assignment, for simulation only.
REQ-003 SHALL have parameter CNT_W, default 16: width of the toggle-bit counter.
REQ-004 SHALL have parameter ZERO_SUPPRESS, default 0: when 1, all-zero toggle vectors are not emitted.
REQ-005 SHALL use one clock and an asynchronous active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 q_in  input  SIZE  toggle-state vector driven by a T-flip-flop vector.
REQ-009 en  input  1  sample strobe; q_in is valid on this cycle.
REQ-010 clr  input  1  synchronous clear; returns the block to post-reset state.
REQ-011 out_ready  input  1  consumer accepts t_out this cycle.
REQ-012 t_out  output  SIZE  recovered toggle vector, t_out = q_in(now) ^ q_in(previous sample).
REQ-013 t_valid  output  1  t_out holds an unconsumed result.
REQ-014 primed  output  1  a reference sample has been captured.
REQ-015 toggle_cnt  output  CNT_W  saturating count of toggled bits since reset or clr.
REQ-016 overflow  output  1  sticky flag: a result was dropped.

Function
REQ-017 SHALL implement a two-state FSM: UNPRIMED and RUN; primed = (state == RUN).
REQ-018 In UNPRIMED with en=1, SHALL capture q_in into q_prev, move to RUN, and emit no result.
REQ-019 In RUN with en=1, SHALL compute t = q_in ^ q_prev and update q_prev to q_in in the same cycle.
REQ-020 SHALL present t on t_out with t_valid=1 on the cycle after the en cycle (latency 1).
REQ-021 When ZERO_SUPPRESS=1 and t == 0, SHALL emit no result, while still updating q_prev.
REQ-022 t_out/t_valid SHALL hold stable while t_valid=1 and out_ready=0.
REQ-023 A transfer SHALL occur on any cycle where t_valid=1 and out_ready=1; t_valid then deasserts next cycle unless a new result loads.
REQ-024 A new result arriving on a transfer cycle SHALL replace the output, with t_valid staying 1 and overflow unchanged.
REQ-025 A new result arriving while t_valid=1 and out_ready=0 SHALL be dropped, keeping the held t_out, and SHALL set overflow; q_prev still updates.
REQ-026 On every RUN sample, SHALL add popcount(t) to toggle_cnt, saturating at 2^CNT_W-1 with no wrap.
REQ-027 A toggle_cnt update SHALL occur regardless of output acceptance or suppression.
REQ-028 en=0 SHALL leave q_prev, state, and toggle_cnt unchanged.
REQ-029 clr=1 SHALL take priority over en; it SHALL force UNPRIMED, clear t_valid, t_out, q_prev, toggle_cnt and overflow, and ignore en that cycle.

Reset
REQ-030 While reset=0, all state SHALL clear asynchronously: state=UNPRIMED, q_prev=0, t_out=0, t_valid=0, primed=0, toggle_cnt=0, overflow=0.
REQ-031 Reset asserted mid-operation SHALL discard any pending t_valid result; the first en after release only re-primes.
REQ-032 Outputs SHALL be registered with no combinational path from inputs.

Verification
REQ-033 Reset release, out_ready=1, then en with q_in=4'b0000, then en with q_in=4'b0101 -> first en gives primed=1 and no t_valid; second gives t_out=4'b0101, t_valid=1 one cycle later, toggle_cnt=2.
REQ-034 Drive a xup_tff_en_reset_vector with t=4'b1010, 4'b0011, 4'b1111 on successive enabled cycles and feed its q into q_in, out_ready=1 -> t_out reproduces 1010, 0011, 1111 in order; toggle_cnt=8.
REQ-035 out_ready=0, two RUN samples producing 4'b0001 then 4'b1000 -> t_out stays 4'b0001, overflow=1; later out_ready=1 transfers 0001, and the next sample's t is computed against the 1000-state q_prev.
REQ-036 ZERO_SUPPRESS=1, repeated en with identical q_in=4'b1100 -> t_valid never asserts, toggle_cnt unchanged; CNT_W=4 with 5 samples of t=4'b1111 -> toggle_cnt saturates at 15.
REQ-037 clr and en asserted together while t_valid=1 and overflow=1 -> next cycle primed=0, t_valid=0, overflow=0, toggle_cnt=0; reset pulsed low mid-stream -> all outputs 0 immediately, without waiting for clk.
